// File: rtl/key_entry_ctrl_if.sv
// Raw key/button inputs and conditioned strobes between the front panel
// and the combination-lock core.
interface key_entry_if;
    logic [3:0] sw_raw;
    logic       btn_cmp_raw;
    logic       btn_lock_raw;
    logic       A;
    logic       B;
    logic       C;
    logic       D;
    logic       encmp;
    logic       enlock;
    logic       busy;

    modport master (
        output sw_raw, btn_cmp_raw, btn_lock_raw,
        input  A, B, C, D, encmp, enlock, busy
    );

    modport slave (
        input  sw_raw, btn_cmp_raw, btn_lock_raw,
        output A, B, C, D, encmp, enlock, busy
    );
endinterface

// File: rtl/key_entry_ctrl.sv
// Synchronizes and debounces the key switches and buttons, then issues
// rate-limited compare strobes and lock strobes to the lock core.
module key_entry_ctrl #(
    parameter int DEB_CYCLES     = 20,
    parameter int SETTLE_CYCLES  = 8,
    parameter int HOLDOFF_CYCLES = 50
) (
    input  logic         clk,
    input  logic         rst,
    key_entry_if.slave   kif
);

    localparam int DCW  = $clog2(DEB_CYCLES + 1);
    localparam int FMAX = (SETTLE_CYCLES > HOLDOFF_CYCLES) ? SETTLE_CYCLES : HOLDOFF_CYCLES;
    localparam int FCW  = $clog2(FMAX + 1);

    typedef enum logic [1:0] {IDLE, SETTLE, FIRE, HOLDOFF} state_t;

    logic [5:0]     raw;
    logic [5:0]     sync_p0;
    logic [5:0]     sync_p1;
    logic [5:0]     deb;
    logic [1:0]     btn_d;
    logic [DCW-1:0] deb_cnt [6];

    logic           cmp_edge;
    logic           lock_edge;
    logic [3:0]     sw_deb;
    logic [3:0]     sw_q;

    state_t         state;
    state_t         state_nx;
    logic [FCW-1:0] cnt;
    logic [FCW-1:0] cnt_nx;
    logic           encmp_q;
    logic           enlock_q;

    assign raw = {kif.btn_lock_raw, kif.btn_cmp_raw, kif.sw_raw};

    // Two-flop synchronizer, then one debouncer per input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            deb     <= '0;
            btn_d   <= '0;
            for (int i = 0; i < 6; i++) deb_cnt[i] <= '0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            btn_d   <= deb[5:4];
            for (int i = 0; i < 6; i++) begin
                if (sync_p1[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DCW'(DEB_CYCLES - 1)) begin
                    deb[i]     <= ~deb[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign sw_deb    = deb[3:0];
    assign cmp_edge  = deb[4] & ~btn_d[0];
    assign lock_edge = deb[5] & ~btn_d[1];

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (cmp_edge) begin
                    state_nx = SETTLE;
                    cnt_nx   = '0;
                end
            end
            SETTLE: begin
                // sw_q lags sw_deb by one cycle here, so a mismatch is a fresh change
                if (sw_deb != sw_q) begin
                    cnt_nx = '0;
                end else if (cnt == FCW'(SETTLE_CYCLES - 1)) begin
                    state_nx = FIRE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            FIRE: begin
                state_nx = HOLDOFF;
                cnt_nx   = '0;
            end
            HOLDOFF: begin
                if (cnt == FCW'(HOLDOFF_CYCLES - 1)) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
        // A lock press overrides everything, including a compare arriving the same cycle
        if (lock_edge) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            encmp_q  <= 1'b0;
            enlock_q <= 1'b0;
            sw_q     <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            encmp_q  <= (state_nx == FIRE);
            enlock_q <= lock_edge;
            if (state != FIRE) sw_q <= sw_deb;
        end
    end

    assign kif.A      = sw_q[0];
    assign kif.B      = sw_q[1];
    assign kif.C      = sw_q[2];
    assign kif.D      = sw_q[3];
    assign kif.encmp  = encmp_q;
    assign kif.enlock = enlock_q;
    assign kif.busy   = (state != IDLE);

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Self-checking bench for key_entry_ctrl: strobe timing is tracked with
// expectation queues that are drained as strobes appear.
module tb_key_entry_ctrl;

    localparam int DEB = 4;
    localparam int SET = 3;
    localparam int HLD = 6;
    localparam int CMP_LAT  = DEB + SET + 3;
    localparam int LOCK_LAT = DEB + 3;

    logic clk;
    logic rst;

    key_entry_if kif();

    key_entry_ctrl #(
        .DEB_CYCLES(DEB),
        .SETTLE_CYCLES(SET),
        .HOLDOFF_CYCLES(HLD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .kif(kif)
    );

    typedef struct {
        logic [3:0] sw;
        logic       cmp;
        logic       lock;
        logic [3:0] exp_abcd;
        logic       exp_encmp;
        logic       exp_enlock;
    } vec_t;

    vec_t vecs [6];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int exp_cmp_q  [$];
    int exp_lock_q [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one clock, then inspect strobes away from the active edge
    task automatic tick();
        int e;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (!rst && kif.encmp) begin
            if (exp_cmp_q.size() == 0) check("encmp_unexpected", 1, 0);
            else begin
                e = exp_cmp_q.pop_front();
                check("encmp_time", cyc, e);
            end
        end
        if (!rst && kif.enlock) begin
            if (exp_lock_q.size() == 0) check("enlock_unexpected", 1, 0);
            else begin
                e = exp_lock_q.pop_front();
                check("enlock_time", cyc, e);
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_missing_encmp"}, exp_cmp_q.size(), 0);
        check({tag, "_missing_enlock"}, exp_lock_q.size(), 0);
        exp_cmp_q.delete();
        exp_lock_q.delete();
    endtask

    function automatic int outs();
        return int'({kif.D, kif.C, kif.B, kif.A, kif.encmp, kif.enlock, kif.busy});
    endfunction

    initial begin
        int c0;
        int c1;
        int busy_seen;

        vecs[0] = '{4'b0001, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b0};
        vecs[1] = '{4'b0110, 1'b1, 1'b0, 4'b0110, 1'b1, 1'b0};
        vecs[2] = '{4'b1111, 1'b0, 1'b1, 4'b1111, 1'b0, 1'b1};
        vecs[3] = '{4'b1000, 1'b1, 1'b1, 4'b1000, 1'b0, 1'b1};
        vecs[4] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
        vecs[5] = '{4'b1010, 1'b1, 1'b0, 4'b1010, 1'b1, 1'b0};

        // Reset held with every raw input high
        rst = 1'b1;
        kif.sw_raw = 4'hF;
        kif.btn_cmp_raw = 1'b1;
        kif.btn_lock_raw = 1'b1;
        ticks(5);
        check("reset_outputs", outs(), 0);
        rst = 1'b0;
        c0 = cyc;
        exp_lock_q.push_back(c0 + LOCK_LAT);
        ticks(LOCK_LAT);
        check("reset_abcd_after_release", int'({kif.D, kif.C, kif.B, kif.A}), 4'hF);
        ticks(25);
        check_drained("reset_release");
        kif.sw_raw = 4'h0;
        kif.btn_cmp_raw = 1'b0;
        kif.btn_lock_raw = 1'b0;
        ticks(20);

        // Table-driven single presses
        for (int v = 0; v < 6; v++) begin
            kif.sw_raw = vecs[v].sw;
            ticks(15);
            c0 = cyc;
            kif.btn_cmp_raw = vecs[v].cmp;
            kif.btn_lock_raw = vecs[v].lock;
            if (vecs[v].exp_encmp)  exp_cmp_q.push_back(c0 + CMP_LAT);
            if (vecs[v].exp_enlock) exp_lock_q.push_back(c0 + LOCK_LAT);
            ticks(15);
            check($sformatf("vec%0d_abcd", v), int'({kif.D, kif.C, kif.B, kif.A}), int'(vecs[v].exp_abcd));
            kif.btn_cmp_raw = 1'b0;
            kif.btn_lock_raw = 1'b0;
            ticks(20);
            check($sformatf("vec%0d_busy_idle", v), int'(kif.busy), 0);
            check_drained($sformatf("vec%0d", v));
        end

        // Bouncing compare button, then a clean hold
        kif.sw_raw = 4'b0000;
        ticks(15);
        for (int i = 0; i < 10; i++) begin
            kif.btn_cmp_raw = (i % 2 == 0);
            ticks(2);
        end
        kif.btn_cmp_raw = 1'b1;
        c0 = cyc;
        exp_cmp_q.push_back(c0 + CMP_LAT);
        ticks(30);
        kif.btn_cmp_raw = 1'b0;
        ticks(20);
        check_drained("bounce");

        // Switch change lands one cycle after SETTLE entry and restarts the window
        kif.sw_raw = 4'b1010;
        ticks(15);
        c0 = cyc;
        kif.btn_cmp_raw = 1'b1;
        ticks(2);
        kif.sw_raw = 4'b1011;
        c1 = cyc + DEB + 2;
        exp_cmp_q.push_back(c1 + 1 + SET);
        ticks(c1 + 1 + SET - cyc);
        check("settle_encmp_high", int'(kif.encmp), 1);
        check("settle_abcd_in_fire", int'({kif.D, kif.C, kif.B, kif.A}), 4'b1011);
        ticks(15);
        kif.btn_cmp_raw = 1'b0;
        ticks(20);
        check_drained("settle");

        // Second press debounced inside HOLDOFF is dropped; a later one fires
        c0 = cyc;
        kif.btn_cmp_raw = 1'b1;
        exp_cmp_q.push_back(c0 + CMP_LAT);
        ticks(4);
        kif.btn_cmp_raw = 1'b0;
        ticks(4);
        kif.btn_cmp_raw = 1'b1;
        ticks(6);
        check("holdoff_busy", int'(kif.busy), 1);
        ticks(14);
        check_drained("holdoff_drop");
        kif.btn_cmp_raw = 1'b0;
        ticks(10);
        c1 = cyc;
        kif.btn_cmp_raw = 1'b1;
        exp_cmp_q.push_back(c1 + CMP_LAT);
        ticks(20);
        kif.btn_cmp_raw = 1'b0;
        ticks(20);
        check_drained("holdoff_again");

        // Compare and lock rising together: lock wins
        c0 = cyc;
        kif.btn_cmp_raw = 1'b1;
        kif.btn_lock_raw = 1'b1;
        exp_lock_q.push_back(c0 + LOCK_LAT);
        busy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (kif.busy) busy_seen = 1;
        end
        check("prio_busy_never", busy_seen, 0);
        kif.btn_cmp_raw = 1'b0;
        kif.btn_lock_raw = 1'b0;
        ticks(15);
        check_drained("prio");

        // Lock arriving during SETTLE aborts the compare
        c0 = cyc;
        kif.btn_cmp_raw = 1'b1;
        ticks(2);
        kif.btn_lock_raw = 1'b1;
        exp_lock_q.push_back(cyc + LOCK_LAT);
        ticks(6);
        check("abort_busy_in_settle", int'(kif.busy), 1);
        tick();
        check("abort_busy_after_lock", int'(kif.busy), 0);
        ticks(20);
        kif.btn_cmp_raw = 1'b0;
        kif.btn_lock_raw = 1'b0;
        ticks(15);
        check_drained("abort");

        // Asynchronous reset mid-SETTLE with the compare button still held
        kif.sw_raw = 4'b0101;
        ticks(15);
        kif.btn_cmp_raw = 1'b1;
        ticks(DEB + 4);
        check("midrst_busy_before", int'(kif.busy), 1);
        rst = 1'b1;
        #1;
        check("midrst_outputs", outs(), 0);
        ticks(3);
        rst = 1'b0;
        c1 = cyc;
        exp_cmp_q.push_back(c1 + CMP_LAT);
        ticks(25);
        kif.btn_cmp_raw = 1'b0;
        ticks(20);
        check_drained("midrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
